// File: rtl/lif_neuron_chain.sv
// Purpose : chain of N leaky integrate-and-fire neurons, neuron i>0 driven by neuron i-1 spikes.
// Latency : a firing stim shows on spikes[0] after its edge; +1 cycle per stage; spike_out N cycles later.
// Backpressure: none; ena=0 freezes potentials, refractory counters and spike_count, spikes forced 0.
//
// Ports:
//   clk, reset          single clock (rising edge), asynchronous active-high reset
//   ena                 1 = network advances one step per cycle, 0 = freeze
//   stim, stim_valid    input current for neuron 0, applied only when stim_valid=1
//   threshold           shared firing threshold; 0 disables firing everywhere
//   weight              shared synaptic weight added to neuron i on a spike of neuron i-1
//   count_clr           synchronous clear of spike_count, dominates an increment
//   spikes              registered 1-cycle spike pulses, bit i = neuron i
//   spike_out           last neuron's spike pulse
//   spike_count         saturating count of spike_out pulses
//   v_out               packed membrane potentials, neuron i at [i*VW +: VW]
module lif_neuron_chain #(
  parameter int N          = 4,
  parameter int VW         = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 4,
  parameter int CW         = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ena,
  input  logic [VW-1:0]   stim,
  input  logic            stim_valid,
  input  logic [VW-1:0]   threshold,
  input  logic [VW-1:0]   weight,
  input  logic            count_clr,
  output logic [N-1:0]    spikes,
  output logic            spike_out,
  output logic [CW-1:0]   spike_count,
  output logic [N*VW-1:0] v_out
);

  // Refractory counter sized for the full 0..255 range of REFRACT.
  localparam int RCW = 8;
  localparam logic [RCW-1:0] RC_INIT = RCW'(REFRACT);

  logic [N-1:0]  spikes_q;
  logic [CW-1:0] cnt_q;

  for (genvar i = 0; i < N; i++) begin : g_neuron
    logic [VW-1:0]  cur;
    logic [VW:0]    vn_full;
    logic [VW-1:0]  vn_sat;
    logic           fire;
    logic [VW-1:0]  v_q;
    logic [RCW-1:0] rc_q;
    logic           spk_q;

    // Neuron 0 takes the external current; later neurons take the weight
    // when their predecessor fired on the previous cycle (registered spike).
    if (i == 0) begin : g_src
      assign cur = stim_valid ? stim : '0;
    end else begin : g_syn
      assign cur = spikes_q[i-1] ? weight : '0;
    end

    // One extra bit holds the sum; v - (v>>LEAK_SHIFT) never underflows,
    // so only the upper bound needs clamping.
    always_comb begin
      vn_full = ({1'b0, v_q} - {1'b0, (v_q >> LEAK_SHIFT)}) + {1'b0, cur};
      vn_sat  = vn_full[VW] ? '1 : vn_full[VW-1:0];
      fire    = (threshold != '0) && (vn_sat >= threshold);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q   <= '0;
        rc_q  <= '0;
        spk_q <= 1'b0;
      end else if (ena) begin
        if (rc_q != '0) begin
          // Refractory: input is dropped, potential pinned at rest.
          rc_q  <= rc_q - RCW'(1);
          v_q   <= '0;
          spk_q <= 1'b0;
        end else if (fire) begin
          rc_q  <= RC_INIT;
          v_q   <= '0;
          spk_q <= 1'b1;
        end else begin
          v_q   <= vn_sat;
          spk_q <= 1'b0;
        end
      end else begin
        // Frozen: state holds but pulses must not stretch across the stall.
        spk_q <= 1'b0;
      end
    end

    assign spikes_q[i]          = spk_q;
    assign v_out[i*VW +: VW]    = v_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (count_clr) begin
      cnt_q <= '0;
    end else if (ena && spikes_q[N-1] && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign spikes      = spikes_q;
  assign spike_out   = spikes_q[N-1];
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_neuron_chain.sv
module tb_lif_neuron_chain;
  localparam int N    = 4;
  localparam int VW   = 8;
  localparam int LS   = 3;
  localparam int RF   = 4;
  localparam int CW   = 4;   // narrow counter so saturation is reachable quickly
  localparam int VMAX = (1 << VW) - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            ena;
  logic [VW-1:0]   stim;
  logic            stim_valid;
  logic [VW-1:0]   threshold;
  logic [VW-1:0]   weight;
  logic            count_clr;
  logic [N-1:0]    spikes;
  logic            spike_out;
  logic [CW-1:0]   spike_count;
  logic [N*VW-1:0] v_out;

  lif_neuron_chain #(.N(N), .VW(VW), .LEAK_SHIFT(LS), .REFRACT(RF), .CW(CW)) dut (
    .clk(clk), .reset(reset), .ena(ena), .stim(stim), .stim_valid(stim_valid),
    .threshold(threshold), .weight(weight), .count_clr(count_clr),
    .spikes(spikes), .spike_out(spike_out), .spike_count(spike_count), .v_out(v_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: plain integers, one array entry per neuron.
  int mv[N];
  int mrc[N];
  int msp[N];
  int mcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mrc[i] = 0; msp[i] = 0;
    end
    mcnt = 0;
  endfunction

  function automatic void model_step();
    int nv[N];
    int nrc[N];
    int nsp[N];
    int cur;
    int t;
    for (int i = 0; i < N; i++) begin
      nv[i] = mv[i]; nrc[i] = mrc[i]; nsp[i] = 0;
      if (ena) begin
        if (i == 0) cur = stim_valid ? int'(stim) : 0;
        else        cur = (msp[i-1] != 0) ? int'(weight) : 0;
        if (mrc[i] > 0) begin
          nrc[i] = mrc[i] - 1;
          nv[i]  = 0;
        end else begin
          t = mv[i] - mv[i] / (2 ** LS) + cur;
          if (t > VMAX) t = VMAX;
          if (threshold != 0 && t >= int'(threshold)) begin
            nsp[i] = 1; nv[i] = 0; nrc[i] = RF;
          end else begin
            nv[i] = t;
          end
        end
      end
    end
    if (count_clr) mcnt = 0;
    else if (ena && msp[N-1] != 0 && mcnt < CMAX) mcnt++;
    for (int i = 0; i < N; i++) begin
      mv[i] = nv[i]; mrc[i] = nrc[i]; msp[i] = nsp[i];
    end
  endfunction

  task automatic compare_model(input string tag);
    logic [N-1:0] es;
    for (int i = 0; i < N; i++) es[i] = (msp[i] != 0);
    check({tag, "_spikes"}, spikes, es);
    check({tag, "_spike_out"}, spike_out, es[N-1]);
    check({tag, "_count"}, spike_count, mcnt);
    for (int i = 0; i < N; i++) check({tag, "_v"}, v_out[i*VW +: VW], mv[i]);
  endtask

  // Advance one clock: model and DUT see the same stable inputs, then
  // outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic e, input int s, input logic sv, input int thr,
                        input int w, input logic clr);
    ena = e; stim = VW'(s); stim_valid = sv; threshold = VW'(thr);
    weight = VW'(w); count_clr = clr;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; #2; reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       e;
    int         s;
    logic       sv;
    int         thr;
    int         w;
    logic       clr;
    logic [N-1:0] spk;
    int         v0;
    int         cnt;
  } vec_t;

  vec_t tbl[8];
  logic [N*VW-1:0] snap;
  logic [N-1:0]    seen;
  int              prev_v0;

  initial begin
    // Propagation down the chain, then sub-threshold integration with leak.
    tbl[0] = '{1'b1, 10, 1'b1, 10, 10, 1'b0, 4'b0001, 0, 0};
    tbl[1] = '{1'b1,  0, 1'b0, 10, 10, 1'b0, 4'b0010, 0, 0};
    tbl[2] = '{1'b1,  0, 1'b0, 10, 10, 1'b0, 4'b0100, 0, 0};
    tbl[3] = '{1'b1,  0, 1'b0, 10, 10, 1'b0, 4'b1000, 0, 0};
    tbl[4] = '{1'b1,  0, 1'b0, 10, 10, 1'b0, 4'b0000, 0, 1};
    tbl[5] = '{1'b1,  5, 1'b1, 10, 10, 1'b0, 4'b0000, 5, 1};
    tbl[6] = '{1'b1,  3, 1'b1, 10, 10, 1'b0, 4'b0000, 8, 1};
    tbl[7] = '{1'b1,  0, 1'b0, 10, 10, 1'b0, 4'b0000, 7, 1};

    reset = 1'b1;
    set_in(1'b0, 0, 1'b0, 0, 0, 1'b0);
    model_reset();
    #2;
    check("reset_spikes", spikes, 0);
    check("reset_v_out", v_out, 0);
    check("reset_count", spike_count, 0);
    #10 reset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      set_in(tbl[k].e, tbl[k].s, tbl[k].sv, tbl[k].thr, tbl[k].w, tbl[k].clr);
      step();
      check("tbl_spikes", spikes, tbl[k].spk);
      check("tbl_v0", v_out[VW-1:0], tbl[k].v0);
      check("tbl_count", spike_count, tbl[k].cnt);
      compare_model("tbl");
    end

    // Leak equilibrium below threshold.
    seen = '0;
    set_in(1'b1, 8, 1'b1, 100, 10, 1'b0);
    for (int k = 0; k < 200; k++) begin
      step();
      seen |= spikes;
    end
    compare_model("t2");
    check("t2_v0_settled", (v_out[VW-1:0] >= 64 && v_out[VW-1:0] <= 71), 1);
    check("t2_no_spikes", seen, 0);

    // Refractory period: with held drive, neuron 0 fires every RF+1 cycles.
    pulse_reset();
    set_in(1'b1, 20, 1'b1, 10, 0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      step();
      check("t3_spk0_period", spikes[0], (k % (RF + 1)) == 0);
      check("t3_v0_zero", v_out[VW-1:0], 0);
    end
    compare_model("t3");

    // Saturation without firing.
    pulse_reset();
    set_in(1'b1, 200, 1'b1, 0, 50, 1'b0);
    prev_v0 = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t4_no_wrap", v_out[VW-1:0] >= prev_v0, 1);
      prev_v0 = int'(v_out[VW-1:0]);
      compare_model("t4");
    end
    check("t4_v0_sat", v_out[VW-1:0], VMAX);
    check("t4_no_spikes", spikes, 0);

    // Clear beats a simultaneous increment.
    pulse_reset();
    set_in(1'b1, 10, 1'b1, 10, 10, 1'b0);
    step();
    set_in(1'b1, 0, 1'b0, 10, 10, 1'b0);
    for (int k = 0; k < 4; k++) step();
    check("t5_count_one", spike_count, 1);
    set_in(1'b1, 10, 1'b1, 10, 10, 1'b0);
    step();
    set_in(1'b1, 0, 1'b0, 10, 10, 1'b0);
    for (int k = 0; k < 3; k++) step();
    check("t5_spike_out_high", spike_out, 1);
    set_in(1'b1, 0, 1'b0, 10, 10, 1'b1);
    step();
    check("t5_clr_wins", spike_count, 0);
    compare_model("t5");

    // Freeze with a spike in flight.
    set_in(1'b1, 10, 1'b1, 10, 10, 1'b0);
    step();
    set_in(1'b1, 6, 1'b1, 10, 10, 1'b0);
    step();
    check("t5_inflight", spikes, 4'b0010);
    snap = v_out;
    for (int k = 0; k < 10; k++) begin
      set_in(1'b0, $urandom_range(0, VMAX), 1'b1, 10, 10, 1'b0);
      step();
      check("t5_frozen_v", v_out, snap);
      check("t5_frozen_spikes", spikes, 0);
    end
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, $urandom_range(0, 12), 1'b1, 10, 10, 1'b0);
      step();
      compare_model("t5_resume");
    end

    // Counter saturation.
    pulse_reset();
    set_in(1'b1, 20, 1'b1, 10, 10, 1'b0);
    for (int k = 0; k < 120; k++) begin
      step();
      compare_model("tsat");
    end
    check("tsat_count_hold", spike_count, CMAX);

    // Random traffic with an asynchronous reset dropped in between edges.
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(0, 9) != 0, $urandom_range(0, VMAX), $urandom_range(0, 1) != 0,
             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(10, 120),
             $urandom_range(0, VMAX), $urandom_range(0, 49) == 0);
      step();
      compare_model("rand");
      if (k == 200) begin
        #2 reset = 1'b1;
        #1;
        check("t6_async_spikes", spikes, 0);
        check("t6_async_v_out", v_out, 0);
        check("t6_async_count", spike_count, 0);
        #1 reset = 1'b0;
        model_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
